lab2_proc_mem_resp_unit: RTL and testbench

LAB2_PROC_MEM_RESP_UNIT -- requirements
Module: lab2_proc_mem_resp_unit

---
 rtl/lab2_proc_mem_resp_unit.sv | 178 +++++++++++++++++
 tb/tb_lab2_proc_mem_resp_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_mem_resp_unit.sv
// Single-outstanding word memory answering one request at a time after a fixed wait.
// Defining LAB2_PROC_MEM_RESP_UNIT_STATS_EN adds the num_reads/num_writes counter ports.
package lab2_proc_mem_resp_unit_pkg;
   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;
endpackage

module lab2_proc_mem_resp_unit
   import lab2_proc_mem_resp_unit_pkg::*;
#(
   parameter int p_mem_nwords = 256,
   parameter int p_latency    = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  mem_req_4B_t  memreq_msg,
   input  logic         memreq_val,
   output logic         memreq_rdy,
   output mem_resp_4B_t memresp_msg,
   output logic         memresp_val,
   input  logic         memresp_rdy
`ifdef LAB2_PROC_MEM_RESP_UNIT_STATS_EN
   ,
   output logic [31:0]  num_reads,
   output logic [31:0]  num_writes
`endif
);

   localparam int         IDX_W     = $clog2(p_mem_nwords);
   localparam bit         HAS_WAIT  = (p_latency > 0);
   localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(p_latency - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t           state;
   logic [3:0]       wait_cnt;
   logic [31:0]      mem [p_mem_nwords];

   logic [IDX_W-1:0] idx;
   logic             xfer;
   logic             is_read;
   logic             is_write;
   logic [3:0]       byte_en;
   logic [31:0]      wr_word;
   logic [31:0]      rd_word;
   logic [31:0]      rd_data;
   logic             unused_addr_bits;

   assign idx              = memreq_msg.addr[IDX_W+1:2];
   assign unused_addr_bits = ^memreq_msg.addr[31:IDX_W+2];
   assign xfer             = memreq_val && memreq_rdy;
   assign is_read          = (memreq_msg.type_ == 3'd0);
   assign is_write         = (memreq_msg.type_ == 3'd1) || (memreq_msg.type_ == 3'd2);
   assign rd_word          = mem[idx];

   // Sub-word lanes: write data is replicated across lanes so the byte enables pick the right one.
   always_comb begin
      byte_en = 4'b1111;
      wr_word = memreq_msg.data;
      rd_data = rd_word;
      case (memreq_msg.len)
         2'd1: begin
            byte_en = 4'b0001 << memreq_msg.addr[1:0];
            wr_word = {4{memreq_msg.data[7:0]}};
            case (memreq_msg.addr[1:0])
               2'd0:    rd_data = {24'b0, rd_word[7:0]};
               2'd1:    rd_data = {24'b0, rd_word[15:8]};
               2'd2:    rd_data = {24'b0, rd_word[23:16]};
               default: rd_data = {24'b0, rd_word[31:24]};
            endcase
         end
         2'd2: begin
            byte_en = memreq_msg.addr[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{memreq_msg.data[15:0]}};
            rd_data = {16'b0, memreq_msg.addr[1] ? rd_word[31:16] : rd_word[15:0]};
         end
         default: ;
      endcase
   end

   // Storage commits at the accepting edge and is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (xfer && is_write) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
         end
      end
   end

   // memreq_rdy is registered so it stays low through reset and rises on the first edge after it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         wait_cnt    <= 4'd0;
         memreq_rdy  <= 1'b0;
         memresp_val <= 1'b0;
         memresp_msg <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  memresp_msg.type_  <= memreq_msg.type_;
                  memresp_msg.opaque <= memreq_msg.opaque;
                  memresp_msg.len    <= memreq_msg.len;
                  memresp_msg.data   <= is_read ? rd_data : 32'd0;
                  memresp_msg.test   <= (is_read || is_write) ? 2'b00 : 2'b01;
                  memreq_rdy         <= 1'b0;
                  if (HAS_WAIT) begin
                     state    <= ST_WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end else begin
                     state       <= ST_RESP;
                     memresp_val <= 1'b1;
                  end
               end else begin
                  memreq_rdy <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state       <= ST_RESP;
                  memresp_val <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (memresp_rdy) begin
                  state       <= ST_IDLE;
                  memresp_val <= 1'b0;
                  memreq_rdy  <= 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               memresp_val <= 1'b0;
               memreq_rdy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef LAB2_PROC_MEM_RESP_UNIT_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         num_reads  <= 32'd0;
         num_writes <= 32'd0;
      end else if (xfer) begin
         if (is_read) begin
            num_reads <= num_reads + 32'd1;
         end
         if (is_write) begin
            num_writes <= num_writes + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_lab2_proc_mem_resp_unit.sv
// Directed bench for lab2_proc_mem_resp_unit with one zero-latency and one three-cycle instance.
// Also exercises the LAB2_PROC_MEM_RESP_UNIT_STATS_EN ports when that macro is defined.
module tb_lab2_proc_mem_resp_unit;
   import lab2_proc_mem_resp_unit_pkg::*;

   logic         clk;
   logic         reset;
   mem_req_4B_t  memreq_msg;
   logic         val0;
   logic         val3;
   logic         memresp_rdy;
   logic         rdy0;
   logic         rdy3;
   mem_resp_4B_t resp0;
   mem_resp_4B_t resp3;
   logic         resp_val0;
   logic         resp_val3;
`ifdef LAB2_PROC_MEM_RESP_UNIT_STATS_EN
   logic [31:0]  num_reads0, num_writes0, num_reads3, num_writes3;
`endif

   int vectors;
   int miscompares;

   lab2_proc_mem_resp_unit #(.p_mem_nwords(256), .p_latency(0)) dut0 (
      .clk         (clk),
      .reset       (reset),
      .memreq_msg  (memreq_msg),
      .memreq_val  (val0),
      .memreq_rdy  (rdy0),
      .memresp_msg (resp0),
      .memresp_val (resp_val0),
      .memresp_rdy (memresp_rdy)
`ifdef LAB2_PROC_MEM_RESP_UNIT_STATS_EN
      ,
      .num_reads   (num_reads0),
      .num_writes  (num_writes0)
`endif
   );

   lab2_proc_mem_resp_unit #(.p_mem_nwords(256), .p_latency(3)) dut3 (
      .clk         (clk),
      .reset       (reset),
      .memreq_msg  (memreq_msg),
      .memreq_val  (val3),
      .memreq_rdy  (rdy3),
      .memresp_msg (resp3),
      .memresp_val (resp_val3),
      .memresp_rdy (memresp_rdy)
`ifdef LAB2_PROC_MEM_RESP_UNIT_STATS_EN
      ,
      .num_reads   (num_reads3),
      .num_writes  (num_writes3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic mem_req_4B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                          input logic [31:0] a, input logic [1:0] l,
                                          input logic [31:0] d);
      mem_req_4B_t m;
      m.type_ = t; m.opaque = op; m.addr = a; m.len = l; m.data = d;
      return m;
   endfunction

   function automatic mem_resp_4B_t mk_resp(input logic [2:0] t, input logic [7:0] op,
                                            input logic [1:0] ts, input logic [1:0] l,
                                            input logic [31:0] d);
      mem_resp_4B_t m;
      m.type_ = t; m.opaque = op; m.test = ts; m.len = l; m.data = d;
      return m;
   endfunction

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One full transaction on the chosen instance; lat counts cycles after the accepting cycle.
   task automatic apply_stimulus(input int which, input mem_req_4B_t msg,
                                 output mem_resp_4B_t resp, output int lat,
                                 output bit rdy_seen);
      int guard;
      guard = 0;
      while (!(which == 0 ? rdy0 : rdy3) && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      memreq_msg = msg;
      if (which == 0) val0 = 1'b1; else val3 = 1'b1;
      @(posedge clk); #1;
      val0 = 1'b0;
      val3 = 1'b0;
      lat = 0;
      rdy_seen = 1'b0;
      while (!(which == 0 ? resp_val0 : resp_val3) && lat < 30) begin
         if (which == 0 ? rdy0 : rdy3) rdy_seen = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      if (which == 0 ? rdy0 : rdy3) rdy_seen = 1'b1;
      resp = (which == 0) ? resp0 : resp3;
      @(posedge clk); #1;
   endtask

   initial begin
      mem_resp_4B_t r;
      int           lat;
      bit           rdy_seen;
      int           guard;
      bit           val_seen;

      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      memreq_msg  = '0;
      val0        = 1'b0;
      val3        = 1'b0;
      memresp_rdy = 1'b1;

      #3;
      check_output("reset_resp_val", 64'(resp_val3), 64'd0);
      check_output("reset_req_rdy", 64'(rdy3), 64'd0);
      check_output("reset_resp_msg", 64'(resp3), 64'd0);
      #5 reset = 1'b1;
      #1;
      check_output("rdy_before_first_edge", 64'(rdy3), 64'd0);
      @(posedge clk); #1;
      check_output("rdy_after_first_edge", 64'(rdy3), 64'd1);
      check_output("rdy0_after_first_edge", 64'(rdy0), 64'd1);

      // Zero-latency instance: word write then read back.
      apply_stimulus(0, mk_req(3'd1, 8'h11, 32'h100, 2'd0, 32'hDEADBEEF), r, lat, rdy_seen);
      check_output("lat0_write_resp", 64'(r), 64'(mk_resp(3'd1, 8'h11, 2'b00, 2'd0, 32'd0)));
      check_output("lat0_write_latency", 64'(lat), 64'd0);
      apply_stimulus(0, mk_req(3'd0, 8'h12, 32'h100, 2'd0, 32'd0), r, lat, rdy_seen);
      check_output("lat0_read_resp", 64'(r), 64'(mk_resp(3'd0, 8'h12, 2'b00, 2'd0, 32'hDEADBEEF)));
      check_output("lat0_read_latency", 64'(lat), 64'd0);

      // Three-cycle instance: init, then latency and ready-low window.
      apply_stimulus(1, mk_req(3'd2, 8'h20, 32'h200, 2'd0, 32'h11223344), r, lat, rdy_seen);
      check_output("init_resp", 64'(r), 64'(mk_resp(3'd2, 8'h20, 2'b00, 2'd0, 32'd0)));
      check_output("lat3_latency", 64'(lat), 64'd3);
      check_output("lat3_rdy_low", 64'(rdy_seen), 64'd0);

      apply_stimulus(1, mk_req(3'd1, 8'h21, 32'h203, 2'd1, 32'h000000AB), r, lat, rdy_seen);
      check_output("byte_write_resp", 64'(r), 64'(mk_resp(3'd1, 8'h21, 2'b00, 2'd1, 32'd0)));
      apply_stimulus(1, mk_req(3'd0, 8'h22, 32'h200, 2'd0, 32'd0), r, lat, rdy_seen);
      check_output("word_after_byte", 64'(r), 64'(mk_resp(3'd0, 8'h22, 2'b00, 2'd0, 32'hAB223344)));
      apply_stimulus(1, mk_req(3'd0, 8'h23, 32'h202, 2'd2, 32'd0), r, lat, rdy_seen);
      check_output("half_read_hi", 64'(r), 64'(mk_resp(3'd0, 8'h23, 2'b00, 2'd2, 32'h0000AB22)));
      apply_stimulus(1, mk_req(3'd0, 8'h24, 32'h200, 2'd2, 32'd0), r, lat, rdy_seen);
      check_output("half_read_lo", 64'(r), 64'(mk_resp(3'd0, 8'h24, 2'b00, 2'd2, 32'h00003344)));
      apply_stimulus(1, mk_req(3'd0, 8'h25, 32'h201, 2'd1, 32'd0), r, lat, rdy_seen);
      check_output("byte_read", 64'(r), 64'(mk_resp(3'd0, 8'h25, 2'b00, 2'd1, 32'h00000033)));

      // Address wrap, len 3 as full word, and an unsupported type.
      apply_stimulus(1, mk_req(3'd1, 8'h30, 32'h000, 2'd0, 32'hCAFEF00D), r, lat, rdy_seen);
      apply_stimulus(1, mk_req(3'd0, 8'h31, 32'h400, 2'd0, 32'd0), r, lat, rdy_seen);
      check_output("wrap_read", 64'(r), 64'(mk_resp(3'd0, 8'h31, 2'b00, 2'd0, 32'hCAFEF00D)));
      apply_stimulus(1, mk_req(3'd0, 8'h32, 32'h400, 2'd3, 32'd0), r, lat, rdy_seen);
      check_output("len3_read", 64'(r), 64'(mk_resp(3'd0, 8'h32, 2'b00, 2'd3, 32'hCAFEF00D)));
      apply_stimulus(1, mk_req(3'd3, 8'h33, 32'h000, 2'd0, 32'h12345678), r, lat, rdy_seen);
      check_output("bad_type_resp", 64'(r), 64'(mk_resp(3'd3, 8'h33, 2'b01, 2'd0, 32'd0)));
      apply_stimulus(1, mk_req(3'd0, 8'h34, 32'h000, 2'd0, 32'd0), r, lat, rdy_seen);
      check_output("bad_type_no_write", 64'(r), 64'(mk_resp(3'd0, 8'h34, 2'b00, 2'd0, 32'hCAFEF00D)));

      // Backpressure with a competing write held on the request side.
      memresp_rdy = 1'b0;
      memreq_msg  = mk_req(3'd0, 8'h40, 32'h200, 2'd0, 32'd0);
      val3        = 1'b1;
      @(posedge clk); #1;
      val3  = 1'b0;
      guard = 0;
      while (!resp_val3 && guard < 30) begin
         @(posedge clk); #1;
         guard++;
      end
      memreq_msg = mk_req(3'd1, 8'h41, 32'h200, 2'd0, 32'h0BADF00D);
      val3       = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_output("bp_val", 64'(resp_val3), 64'd1);
         check_output("bp_msg", 64'(resp3), 64'(mk_resp(3'd0, 8'h40, 2'b00, 2'd0, 32'hAB223344)));
         check_output("bp_req_rdy", 64'(rdy3), 64'd0);
      end
      val3        = 1'b0;
      memresp_rdy = 1'b1;
      @(posedge clk); #1;
      check_output("bp_release_val", 64'(resp_val3), 64'd0);
      check_output("bp_release_rdy", 64'(rdy3), 64'd1);
      apply_stimulus(1, mk_req(3'd0, 8'h42, 32'h200, 2'd0, 32'd0), r, lat, rdy_seen);
      check_output("bp_no_accept", 64'(r), 64'(mk_resp(3'd0, 8'h42, 2'b00, 2'd0, 32'hAB223344)));

      // Reset while waiting: response dropped, committed write kept.
      memreq_msg = mk_req(3'd1, 8'h50, 32'h300, 2'd0, 32'h5A5A5A5A);
      val3       = 1'b1;
      @(posedge clk); #1;
      val3 = 1'b0;
      check_output("in_wait_val", 64'(resp_val3), 64'd0);
      #2 reset = 1'b0;
      #1;
      check_output("mid_reset_val", 64'(resp_val3), 64'd0);
      check_output("mid_reset_rdy", 64'(rdy3), 64'd0);
      check_output("mid_reset_msg", 64'(resp3), 64'd0);
`ifdef LAB2_PROC_MEM_RESP_UNIT_STATS_EN
      check_output("stats_reads_reset", 64'(num_reads3), 64'd0);
      check_output("stats_writes_reset", 64'(num_writes3), 64'd0);
`endif
      #3 reset = 1'b1;
      val_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (resp_val3) val_seen = 1'b1;
      end
      check_output("no_resp_after_reset", 64'(val_seen), 64'd0);
      apply_stimulus(1, mk_req(3'd0, 8'h51, 32'h300, 2'd0, 32'd0), r, lat, rdy_seen);
      check_output("write_survives_reset", 64'(r), 64'(mk_resp(3'd0, 8'h51, 2'b00, 2'd0, 32'h5A5A5A5A)));
`ifdef LAB2_PROC_MEM_RESP_UNIT_STATS_EN
      check_output("stats_reads_one", 64'(num_reads3), 64'd1);
      check_output("stats_writes_zero", 64'(num_writes3), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
